access_grant_fsm: RTL and testbench

//  Upstream write-request gate for the user-ID protected data register.

---
 rtl/acg_pkg.sv | 34 +++
 rtl/acg_lockout_timer.sv | 65 ++++++
 rtl/access_grant_fsm.sv | 169 ++++++++++++++++
 tb/tb_access_grant_fsm.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acg_pkg.sv
// -----------------------------------------------------------------------------
// acg_pkg
//   Shared types and constants for the access-grant write gate.
//
//   Contents:
//     acg_state_e      gate FSM state (IDLE / CHECK / GRANT / DENY)
//     AUTH_ID_DEF      default sole user ID permitted to write
//     DENY_CNT_MAX     saturation value of the total-denial counter
//     sat_inc_deny()   saturating increment for the denial counter
//
//   Optional feature macro used by the importing files: ACG_LOCKOUT_EN.
// -----------------------------------------------------------------------------
package acg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        GRANT = 2'd2,
        DENY  = 2'd3
    } acg_state_e;

    localparam int         ID_W_DEF        = 3;
    localparam int         DATA_W_DEF      = 8;
    localparam logic [2:0] AUTH_ID_DEF     = 3'h4;
    localparam int         LOCK_THRESH_DEF = 3;
    localparam int         LOCK_CYCLES_DEF = 16;
    localparam logic [7:0] DENY_CNT_MAX    = 8'hFF;

    // Saturating increment: the counter sticks at DENY_CNT_MAX and never wraps.
    function automatic logic [7:0] sat_inc_deny(input logic [7:0] value);
        return (value == DENY_CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage : acg_pkg

// File: rtl/acg_lockout_timer.sv
// -----------------------------------------------------------------------------
// acg_lockout_timer
//   Consecutive-denial counter plus lockout down-counter. Only built when
//   ACG_LOCKOUT_EN is defined.
//
//   Behaviour:
//     - every denial outside lockout bumps the consecutive count;
//     - any grant clears the consecutive count;
//     - reaching LOCK_THRESH raises locked for exactly LOCK_CYCLES cycles;
//     - denials during lockout neither count nor extend the lockout;
//     - on expiry locked drops and the consecutive count clears.
//
//   Ports:
//     clk     in   rising-edge clock
//     rst_n   in   asynchronous active-low reset
//     deny    in   one-cycle denial indication (gate in DENY)
//     grant   in   one-cycle grant indication (gate in GRANT)
//     locked  out  lockout active, registered
// -----------------------------------------------------------------------------
module acg_lockout_timer #(
    parameter int LOCK_THRESH = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic deny,
    input  logic grant,
    output logic locked
);

    localparam int CW = $clog2(LOCK_THRESH + 1);
    localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [CW-1:0] CONSEC_LAST = CW'(LOCK_THRESH - 1);
    localparam logic [TW-1:0] TIMER_LOAD  = TW'(LOCK_CYCLES - 1);

    logic [CW-1:0] consec;
    logic [TW-1:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            consec <= '0;
            timer  <= '0;
            locked <= 1'b0;
        end else if (locked) begin
            // Timer is loaded with LOCK_CYCLES-1, so locked stays high for
            // LOCK_CYCLES full cycles before this branch releases it.
            if (timer == '0) begin
                locked <= 1'b0;
                consec <= '0;
            end else begin
                timer <= timer - TW'(1);
            end
        end else if (grant) begin
            consec <= '0;
        end else if (deny) begin
            consec <= consec + CW'(1);
            if (consec == CONSEC_LAST) begin
                locked <= 1'b1;
                timer  <= TIMER_LOAD;
            end
        end
    end

endmodule : acg_lockout_timer

// File: rtl/access_grant_fsm.sv
// -----------------------------------------------------------------------------
// access_grant_fsm
//   Upstream write-request gate for the user-ID protected data register.
//   A request is captured on the valid/ready handshake, its ID is checked
//   against AUTH_ID from the captured copy, and only then is a one-cycle
//   wr_en issued together with the captured ID and data. A denied request
//   produces a response pulse and bumps a saturating denial counter.
//
//   Timing: request accepted at edge T -> wr_en / resp_valid in cycle T+2.
//   One request every 3 cycles. All outputs decode registered state or
//   capture registers; req_* has no combinational path to wr_* or resp_*.
//
//   Optional feature: define ACG_LOCKOUT_EN to add consecutive-denial
//   lockout (acg_lockout_timer). Without it locked is tied to 0 and only
//   the ID is checked.
//
//   Ports:
//     clk           in   rising-edge clock
//     rst_n         in   asynchronous active-low reset
//     req_valid     in   write request present
//     req_ready     out  gate can accept a request (IDLE)
//     req_usr_id    in   requester ID            [ID_W]
//     req_data      in   requested write data    [DATA_W]
//     wr_en         out  one-cycle write strobe
//     wr_usr_id     out  captured ID with wr_en  [ID_W]
//     wr_data       out  captured data with wr_en [DATA_W]
//     resp_valid    out  one-cycle decision pulse
//     resp_granted  out  1 = written, 0 = denied (with resp_valid)
//     deny_cnt      out  total denials, saturating at 8'hFF
//     locked        out  lockout active
// -----------------------------------------------------------------------------
module access_grant_fsm
    import acg_pkg::*;
#(
    parameter int              ID_W    = ID_W_DEF,
    parameter int              DATA_W  = DATA_W_DEF,
    parameter logic [ID_W-1:0] AUTH_ID = AUTH_ID_DEF
`ifdef ACG_LOCKOUT_EN
    ,
    parameter int              LOCK_THRESH = LOCK_THRESH_DEF,
    parameter int              LOCK_CYCLES = LOCK_CYCLES_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_usr_id,
    input  logic [DATA_W-1:0] req_data,
    output logic              wr_en,
    output logic [ID_W-1:0]   wr_usr_id,
    output logic [DATA_W-1:0] wr_data,
    output logic              resp_valid,
    output logic              resp_granted,
    output logic [7:0]        deny_cnt,
    output logic              locked
);

    acg_state_e        state;
    acg_state_e        state_nxt;
    logic [ID_W-1:0]   cap_id;
    logic [DATA_W-1:0] cap_data;
    logic              lock_active;
    logic              auth_ok;

    // -------------------------------------------------------------------------
    // Optional lockout
    // -------------------------------------------------------------------------
`ifdef ACG_LOCKOUT_EN
    acg_lockout_timer #(
        .LOCK_THRESH (LOCK_THRESH),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lockout (
        .clk    (clk),
        .rst_n  (rst_n),
        .deny   (state == DENY),
        .grant  (state == GRANT),
        .locked (lock_active)
    );
`else
    assign lock_active = 1'b0;
`endif

    assign locked = lock_active;

    // Decision uses only the captured ID, so req_usr_id changes after the
    // handshake cannot influence the outcome.
    assign auth_ok = (cap_id == AUTH_ID) && !lock_active;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment up front keeps this block free of
    // inferred latches on paths the case does not cover.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = CHECK;
            CHECK:   state_nxt = auth_ok ? GRANT : DENY;
            GRANT:   state_nxt = IDLE;
            DENY:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (registered state only)
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready    = 1'b0;
        wr_en        = 1'b0;
        resp_valid   = 1'b0;
        resp_granted = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            GRANT: begin
                wr_en        = 1'b1;
                resp_valid   = 1'b1;
                resp_granted = 1'b1;
            end
            DENY:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Capture registers
    // -------------------------------------------------------------------------
    // NOTE: capture registers are plain flops, not a memory, so they take
    // the async reset and come out of reset at a known zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_id   <= '0;
            cap_data <= '0;
        end else if (req_valid && req_ready) begin
            cap_id   <= req_usr_id;
            cap_data <= req_data;
        end
    end

    // Held between writes; only meaningful while wr_en is high.
    assign wr_usr_id = cap_id;
    assign wr_data   = cap_data;

    // -------------------------------------------------------------------------
    // Total denial counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deny_cnt <= '0;
        end else if (state == DENY) begin
            deny_cnt <= sat_inc_deny(deny_cnt);
        end
    end

endmodule : access_grant_fsm

// File: tb/tb_access_grant_fsm.sv
// -----------------------------------------------------------------------------
// tb_access_grant_fsm
//   Self-checking bench for access_grant_fsm. A behavioural model tracks the
//   expected decision of each request (ID rule, lockout window in absolute
//   cycle numbers), the saturating denial total and the downstream register.
//   Define ACG_LOCKOUT_EN for both bench and RTL to cover the lockout build.
// -----------------------------------------------------------------------------
module tb_access_grant_fsm;

    localparam int         ID_W   = 3;
    localparam int         DATA_W = 8;
    localparam logic [2:0] AUTH   = 3'h4;
    localparam int         THRESH = 3;
    localparam int         LCYC   = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ID_W-1:0]   req_usr_id = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic              wr_en;
    logic [ID_W-1:0]   wr_usr_id;
    logic [DATA_W-1:0] wr_data;
    logic              resp_valid;
    logic              resp_granted;
    logic [7:0]        deny_cnt;
    logic              locked;

    access_grant_fsm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_usr_id   (req_usr_id),
        .req_data     (req_data),
        .wr_en        (wr_en),
        .wr_usr_id    (wr_usr_id),
        .wr_data      (wr_data),
        .resp_valid   (resp_valid),
        .resp_granted (resp_granted),
        .deny_cnt     (deny_cnt),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    // Absolute cycle number: count of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream protected register, written only by wr_en.
    logic [DATA_W-1:0] data_out = '0;
    always @(posedge clk) if (wr_en) data_out <= wr_data;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int                exp_deny_total = 0;
    int                consec = 0;
    int                lock_lo = 1;      // lockout covers cycles lock_lo..lock_hi
    int                lock_hi = 0;
    logic [DATA_W-1:0] exp_data_out = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_locked(input int c);
        return (c >= lock_lo) && (c <= lock_hi);
    endfunction

    function automatic logic [7:0] exp_deny_cnt();
        return (exp_deny_total > 255) ? 8'hFF : 8'(exp_deny_total);
    endfunction

    // Once the lockout window has passed, the consecutive count restarts.
    task automatic model_settle(input int c);
        if (lock_hi > 0 && c > lock_hi && consec >= THRESH) consec = 0;
    endtask

    task automatic model_reset();
        exp_deny_total = 0;
        consec         = 0;
        lock_lo        = 1;
        lock_hi        = 0;
    endtask

    // Decision recorded in the response cycle c.
    task automatic model_decide(input bit granted, input logic [DATA_W-1:0] data, input int c);
        model_settle(c);
        if (granted) begin
            exp_data_out = data;
            consec       = 0;
        end else begin
            exp_deny_total++;
`ifdef ACG_LOCKOUT_EN
            if (!model_locked(c)) begin
                consec++;
                if (consec == THRESH) begin
                    lock_lo = c + 1;
                    lock_hi = c + LCYC;
                end
            end
`endif
        end
    endtask

    // One full request: called just after a falling edge, returns just after
    // the falling edge of the IDLE cycle that follows the response.
    task automatic do_req(input logic [2:0] id, input logic [7:0] data,
                          input bit swap, input logic [2:0] id2);
        int n;
        int c_chk;
        int c_rsp;
        bit exp_grant;
        n = 0;
        while (!req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", {31'd0, req_ready}, 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_usr_id = id;
        req_data   = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (swap) begin
            req_usr_id = id2;
            req_data   = ~data;
        end
        @(negedge clk);
        c_chk = cyc;
        model_settle(c_chk);
        exp_grant = (id == AUTH) && !model_locked(c_chk);
        check("chk_ready",  {31'd0, req_ready},  32'd0);
        check("chk_wr_en",  {31'd0, wr_en},      32'd0);
        check("chk_resp",   {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        c_rsp = cyc;
        check("rsp_valid",   {31'd0, resp_valid},   32'd1);
        check("rsp_wr_en",   {31'd0, wr_en},        {31'd0, exp_grant});
        check("rsp_granted", {31'd0, resp_granted}, {31'd0, exp_grant});
        check("rsp_locked",  {31'd0, locked},       {31'd0, model_locked(c_rsp)});
        if (exp_grant) begin
            check("wr_usr_id", {29'd0, wr_usr_id}, {29'd0, id});
            check("wr_data",   {24'd0, wr_data},   {24'd0, data});
        end
        model_decide(exp_grant, data, c_rsp);
        @(negedge clk);
        check("idle_ready",    {31'd0, req_ready},  32'd1);
        check("idle_wr_en",    {31'd0, wr_en},      32'd0);
        check("idle_resp",     {31'd0, resp_valid}, 32'd0);
        check("deny_cnt",      {24'd0, deny_cnt},   {24'd0, exp_deny_cnt()});
        check("data_out",      {24'd0, data_out},   {24'd0, exp_data_out});
        check("idle_locked",   {31'd0, locked},     {31'd0, model_locked(cyc)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] rid;
        logic [2:0] rid2;

        // 1. Reset held two cycles, then released.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en",    {31'd0, wr_en},        32'd0);
        check("rst_resp",     {31'd0, resp_valid},   32'd0);
        check("rst_granted",  {31'd0, resp_granted}, 32'd0);
        check("rst_deny_cnt", {24'd0, deny_cnt},     32'd0);
        check("rst_locked",   {31'd0, locked},       32'd0);
        check("rst_wr_data",  {24'd0, wr_data},      32'd0);
        check("rst_wr_id",    {29'd0, wr_usr_id},    32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // 2. Authorised write.
        do_req(3'd4, 8'hAB, 1'b0, 3'd0);
        check("t2_data_out", {24'd0, data_out}, 32'h000000AB);

        // 3. Unauthorised ID.
        do_req(3'd3, 8'hCD, 1'b0, 3'd0);
        check("t3_deny_cnt", {24'd0, deny_cnt}, 32'd1);
        check("t3_data_out", {24'd0, data_out}, 32'h000000AB);

        // 4. ID changed to AUTH during CHECK must not matter.
        do_req(3'd3, 8'h5A, 1'b1, 3'd4);
        check("t4_data_out", {24'd0, data_out}, 32'h000000AB);

        // Clear any consecutive history with a grant.
        do_req(3'd4, 8'h11, 1'b0, 3'd0);

`ifdef ACG_LOCKOUT_EN
        // 5. Three denials trigger lockout; AUTH denied inside, granted after.
        repeat (3) do_req(3'd3, 8'h22, 1'b0, 3'd0);
        check("t5_locked", {31'd0, locked}, 32'd1);
        do_req(3'd4, 8'h33, 1'b0, 3'd0);
        check("t5_auth_denied", {24'd0, data_out}, 32'h00000011);
        repeat (20) @(negedge clk);
        check("t5_unlocked", {31'd0, locked}, 32'd0);
        do_req(3'd4, 8'h44, 1'b0, 3'd0);
        check("t5_auth_granted", {24'd0, data_out}, 32'h00000044);
`endif

        // Randomised mix checked against the model.
        for (int i = 0; i < 80; i++) begin
            rid  = ($urandom_range(0, 1) == 1) ? 3'd4 : 3'($urandom_range(0, 7));
            rid2 = 3'($urandom_range(0, 7));
            do_req(rid, 8'($urandom), ($urandom_range(0, 3) == 0), rid2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // 6. Reset during CHECK of an authorised request.
        req_valid  = 1'b1;
        req_usr_id = 3'd4;
        req_data   = 8'hEE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_wr_en",    {31'd0, wr_en},      32'd0);
        check("t6_rst_resp",     {31'd0, resp_valid}, 32'd0);
        check("t6_rst_ready",    {31'd0, req_ready},  32'd1);
        check("t6_rst_deny_cnt", {24'd0, deny_cnt},   32'd0);
        check("t6_rst_wr_data",  {24'd0, wr_data},    32'd0);
        @(negedge clk);
        check("t6_hold_wr_en", {31'd0, wr_en}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_idle_ready", {31'd0, req_ready},  32'd1);
        check("t6_idle_wr_en", {31'd0, wr_en},      32'd0);
        @(negedge clk);
        check("t6_no_late_wr", {31'd0, wr_en},      32'd0);
        check("t6_data_out",   {24'd0, data_out},   {24'd0, exp_data_out});

        // 300 denials: deny_cnt saturates at 0xFF.
        for (int i = 0; i < 300; i++) begin
            do_req(3'($urandom_range(0, 3)), 8'($urandom), 1'b0, 3'd0);
        end
        check("sat_deny_cnt", {24'd0, deny_cnt}, 32'h000000FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_access_grant_fsm
